// File: rtl/tree_traversal_unit_if.sv
// tree_traversal_unit_if: start/result handshakes and node/feature memory ports of the tree walker
interface tree_traversal_unit_if #(
  parameter int DATA_W    = 32,
  parameter int NODE_AW   = 8,
  parameter int FEAT_AW   = 5,
  parameter int CLASS_W   = 8,
  parameter int MAX_DEPTH = 16
);
  localparam int DEPTH_W = $clog2(MAX_DEPTH + 1);
  logic                 start_valid;
  logic                 start_ready;
  logic [NODE_AW-1:0]   root_addr;
  logic                 node_rd_en;
  logic [NODE_AW-1:0]   node_addr;
  logic                 node_is_leaf;
  logic [FEAT_AW-1:0]   node_feat;
  logic [DATA_W-1:0]    node_thresh;
  logic [NODE_AW-1:0]   node_left;
  logic [NODE_AW-1:0]   node_right;
  logic [CLASS_W-1:0]   node_class;
  logic                 feat_rd_en;
  logic [FEAT_AW-1:0]   feat_addr;
  logic [DATA_W-1:0]    feat_rdata;
  logic                 res_valid;
  logic                 res_ready;
  logic [CLASS_W-1:0]   res_class;
  logic [DEPTH_W-1:0]   res_depth;
  logic [MAX_DEPTH-1:0] res_path;
  logic                 res_err;
  modport slave (
    input  start_valid, root_addr, node_is_leaf, node_feat, node_thresh, node_left,
           node_right, node_class, feat_rdata, res_ready,
    output start_ready, node_rd_en, node_addr, feat_rd_en, feat_addr, res_valid,
           res_class, res_depth, res_path, res_err
  );
  modport master (
    output start_valid, root_addr, node_is_leaf, node_feat, node_thresh, node_left,
           node_right, node_class, feat_rdata, res_ready,
    input  start_ready, node_rd_en, node_addr, feat_rd_en, feat_addr, res_valid,
           res_class, res_depth, res_path, res_err
  );
endinterface

// File: rtl/tree_traversal_unit.sv
// tree_traversal_unit: walks one decision tree from root to leaf, one node per three cycles
module tree_traversal_unit #(
  parameter int DATA_W     = 32,
  parameter int NODE_AW    = 8,
  parameter int FEAT_AW    = 5,
  parameter int CLASS_W    = 8,
  parameter int MAX_DEPTH  = 16,
  parameter int CMP_SIGNED = 0
) (
  input logic clk,
  input logic reset,
  tree_traversal_unit_if.slave io
);
  localparam int DW = $clog2(MAX_DEPTH + 1);
  typedef enum logic [2:0] {IDLE, NODE, NLAT, FLAT, DONE} state_t;
  state_t               state, nxt;
  logic [NODE_AW-1:0]   cur, left, right;
  logic [DATA_W-1:0]    thresh;
  logic [FEAT_AW-1:0]   feat_addr_q;
  logic [DW-1:0]        depth, depth_nx;
  logic [MAX_DEPTH-1:0] path;
  logic [CLASS_W-1:0]   cls;
  logic                 err, dec, last;
  assign dec = (CMP_SIGNED != 0) ? ($signed(io.feat_rdata) > $signed(thresh))
                                 : (io.feat_rdata > thresh);
  assign depth_nx = depth + DW'(1);
  assign last = depth_nx == DW'(MAX_DEPTH);
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= nxt;
  always_comb
    nxt = state == IDLE ? (io.start_valid ? NODE : IDLE) :
          state == NODE ? NLAT :
          state == NLAT ? (io.node_is_leaf ? DONE : FLAT) :
          state == FLAT ? (last ? DONE : NODE) :
          state == DONE ? (io.res_ready ? IDLE : DONE) : IDLE;
  // feature address comes straight from the node record so the feature read overlaps NLAT
  always_comb begin
    io.start_ready = state == IDLE;
    io.node_rd_en  = state == NODE;
    io.node_addr   = cur;
    io.feat_rd_en  = state == NLAT && !io.node_is_leaf;
    io.feat_addr   = state == NLAT ? io.node_feat : feat_addr_q;
    io.res_valid   = state == DONE;
    io.res_class   = cls;
    io.res_depth   = depth;
    io.res_path    = path;
    io.res_err     = err;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cur         <= '0;
      left        <= '0;
      right       <= '0;
      thresh      <= '0;
      feat_addr_q <= '0;
      depth       <= '0;
      path        <= '0;
      cls         <= '0;
      err         <= 1'b0;
    end else begin
      case (state)
        IDLE:
          if (io.start_valid) begin
            cur   <= io.root_addr;
            depth <= '0;
            path  <= '0;
            cls   <= '0;
            err   <= 1'b0;
          end
        NLAT:
          if (io.node_is_leaf) cls <= io.node_class;
          else begin
            feat_addr_q <= io.node_feat;
            thresh      <= io.node_thresh;
            left        <= io.node_left;
            right       <= io.node_right;
          end
        FLAT: begin
          path  <= path | (MAX_DEPTH'(dec) << depth);
          cur   <= dec ? right : left;
          depth <= depth_nx;
          if (last) begin
            err <= 1'b1;
            cls <= '0;
          end
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_tree_traversal_unit.sv
// tb_tree_traversal_unit: unsigned and signed instances walked in lockstep against a tree-walk model
module tb_tree_traversal_unit;
  localparam int MD = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sv = 1'b0;
  logic rr = 1'b1;
  logic [7:0] root = '0;
  always #5 clk = ~clk;

  logic        leaf[256];
  logic [4:0]  nfeat[256];
  logic [31:0] nth[256];
  logic [7:0]  nl[256], nrt[256], ncls[256];
  logic [31:0] fmem[32];

  logic       s_ready[2], s_valid[2], s_nrd[2], s_frd[2], s_err[2];
  logic [7:0] s_class[2], s_naddr[2];
  logic [2:0] s_depth[2];
  logic [3:0] s_path[2];
  logic [4:0] s_faddr[2];

  int vectors = 0;
  int miscompares = 0;

  tree_traversal_unit_if #(.MAX_DEPTH(MD)) io [2] ();

  for (genvar g = 0; g < 2; g++) begin : gi
    tree_traversal_unit #(.MAX_DEPTH(MD), .CMP_SIGNED(g)) u_dut (.clk(clk), .reset(reset), .io(io[g]));
    assign io[g].start_valid = sv;
    assign io[g].root_addr   = root;
    assign io[g].res_ready   = rr;
    always @(posedge clk) begin
      if (io[g].node_rd_en) begin
        io[g].node_is_leaf <= leaf[io[g].node_addr];
        io[g].node_feat    <= nfeat[io[g].node_addr];
        io[g].node_thresh  <= nth[io[g].node_addr];
        io[g].node_left    <= nl[io[g].node_addr];
        io[g].node_right   <= nrt[io[g].node_addr];
        io[g].node_class   <= ncls[io[g].node_addr];
      end
      if (io[g].feat_rd_en) io[g].feat_rdata <= fmem[io[g].feat_addr];
    end
    assign s_ready[g] = io[g].start_ready;
    assign s_valid[g] = io[g].res_valid;
    assign s_nrd[g]   = io[g].node_rd_en;
    assign s_frd[g]   = io[g].feat_rd_en;
    assign s_err[g]   = io[g].res_err;
    assign s_class[g] = io[g].res_class;
    assign s_naddr[g] = io[g].node_addr;
    assign s_depth[g] = io[g].res_depth;
    assign s_path[g]  = io[g].res_path;
    assign s_faddr[g] = io[g].feat_addr;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Walks the tree in memory following the decision rules, giving result and cost.
  function automatic void walk(input logic [7:0] r, input bit sgn, output logic [7:0] cls,
                               output int dep, output logic [3:0] path, output bit err,
                               output int lat, output int nreads, output int freads);
    logic [7:0] c = r;
    logic [31:0] f;
    bit d, done = 0;
    cls = 0; dep = 0; path = 0; err = 0; nreads = 0; freads = 0;
    while (!done) begin
      nreads++;
      if (leaf[c]) begin
        cls = ncls[c];
        done = 1;
      end else begin
        freads++;
        f = fmem[nfeat[c]];
        d = sgn ? ($signed(f) > $signed(nth[c])) : (f > nth[c]);
        path[dep] = d;
        c = d ? nrt[c] : nl[c];
        dep++;
        if (dep == MD) begin
          err = 1;
          cls = 0;
          done = 1;
        end
      end
    end
    lat = err ? 3 * MD + 1 : 3 * dep + 3;
  endfunction

  bit         busy[2], fresh[2], merr[2];
  int         cnt[2], mlat[2], mdep[2], rn[2], rf[2], mnr[2], mfr[2];
  logic [7:0] mcls[2];
  logic [3:0] mpath[2];

  always @(negedge clk)
    for (int i = 0; i < 2; i++) begin
      bit ev;
      if (reset) begin
        busy[i] = 0;
        fresh[i] = 1;
      end
      ev = busy[i] && cnt[i] >= mlat[i];
      chk("start_ready", s_ready[i], !busy[i]);
      chk("res_valid", s_valid[i], ev);
      chk("rd_exclusive", s_nrd[i] & s_frd[i], 0);
      if (ev) begin
        chk("res_class", s_class[i], mcls[i]);
        chk("res_depth", s_depth[i], mdep[i]);
        chk("res_path", s_path[i], mpath[i]);
        chk("res_err", s_err[i], merr[i]);
        chk("node_reads", rn[i], mnr[i]);
        chk("feat_reads", rf[i], mfr[i]);
      end
      if (fresh[i]) begin
        chk("rst_class", s_class[i], 0);
        chk("rst_depth", s_depth[i], 0);
        chk("rst_path", s_path[i], 0);
        chk("rst_err", s_err[i], 0);
        chk("rst_node_addr", s_naddr[i], 0);
        chk("rst_feat_addr", s_faddr[i], 0);
        chk("rst_rd_en", {s_nrd[i], s_frd[i]}, 0);
      end
      if (busy[i]) begin
        rn[i] += int'(s_nrd[i]);
        rf[i] += int'(s_frd[i]);
      end
      if (!reset) begin
        if (!busy[i]) begin
          if (sv) begin
            walk(root, i == 1, mcls[i], mdep[i], mpath[i], merr[i], mlat[i], mnr[i], mfr[i]);
            busy[i] = 1; cnt[i] = 1; rn[i] = 0; rf[i] = 0; fresh[i] = 0;
          end
        end else if (ev && rr) busy[i] = 0;
        else cnt[i]++;
      end
    end

  task automatic wait_res(input int lat);
    int cyc = 1;
    while (!s_valid[0] && cyc < 200) begin
      @(posedge clk) #1;
      cyc++;
    end
    chk("latency", cyc, lat);
  endtask

  task automatic run(input logic [7:0] r, input int lat, input logic [7:0] c0, input logic [7:0] c1,
                     input int d, input logic [3:0] p0, input logic [3:0] p1, input logic e);
    root = r;
    sv = 1;
    @(posedge clk) #1;
    sv = 0;
    wait_res(lat);
    chk("lit_class_u", s_class[0], c0);
    chk("lit_class_s", s_class[1], c1);
    chk("lit_depth_u", s_depth[0], d);
    chk("lit_depth_s", s_depth[1], d);
    chk("lit_path_u", s_path[0], p0);
    chk("lit_path_s", s_path[1], p1);
    chk("lit_err_u", s_err[0], e);
    chk("lit_err_s", s_err[1], e);
    @(posedge clk) #1;
  endtask

  task automatic node(input logic [7:0] a, input logic [4:0] f, input logic [31:0] t,
                      input logic [7:0] l, input logic [7:0] r);
    leaf[a] = 0; nfeat[a] = f; nth[a] = t; nl[a] = l; nrt[a] = r;
  endtask

  task automatic lf(input logic [7:0] a, input logic [7:0] c);
    leaf[a] = 1; ncls[a] = c;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      leaf[i] = 0; nfeat[i] = 0; nth[i] = 0; nl[i] = 0; nrt[i] = 0; ncls[i] = 0;
    end
    for (int i = 0; i < 32; i++) fmem[i] = 0;
    fmem[1] = 50; fmem[2] = 25; fmem[3] = 150; fmem[5] = 32'hFFFF_FFFF;
    lf(10, 8'h2A);
    node(20, 3, 100, 30, 21); node(21, 1, 50, 22, 23); lf(22, 7); lf(23, 9); lf(30, 1);
    node(40, 5, 5, 41, 42); lf(41, 8'h11); lf(42, 8'h22);
    node(50, 0, 32'hFFFF_FFFF, 50, 50);
    node(60, 2, 10, 62, 61); node(61, 2, 30, 63, 64); node(63, 2, 20, 65, 66);
    lf(62, 8'h62); lf(64, 8'h64); lf(65, 8'h65); lf(66, 8'h66);
    repeat (2) @(posedge clk);
    #1 reset = 0;
    @(posedge clk) #1;
    chk("reset_start_ready", s_ready[0], 1);
    run(10, 3, 8'h2A, 8'h2A, 0, 0, 0, 0);
    run(20, 9, 7, 7, 2, 4'b0001, 4'b0001, 0);
    run(40, 6, 8'h22, 8'h11, 1, 4'b0001, 4'b0000, 0);
    run(50, 13, 0, 0, 4, 4'b0000, 4'b1111, 1);
    rr = 0;
    root = 10;
    sv = 1;
    @(posedge clk) #1;
    wait_res(3);
    repeat (5) begin
      @(posedge clk) #1;
      chk("hold_start_ready", s_ready[0], 0);
      chk("hold_valid", s_valid[0], 1);
      chk("hold_class", s_class[0], 8'h2A);
    end
    rr = 1;
    @(posedge clk) #1;
    chk("release_idle", s_ready[0], 1);
    @(posedge clk) #1;
    sv = 0;
    chk("reaccept_busy", s_ready[0], 0);
    wait_res(3);
    @(posedge clk) #1;
    root = 60;
    sv = 1;
    @(posedge clk) #1;
    sv = 0;
    repeat (5) @(posedge clk) #1;
    reset = 1;
    #1;
    chk("midrst_start_ready", s_ready[0], 1);
    chk("midrst_valid", s_valid[0], 0);
    chk("midrst_rd_en", {s_nrd[0], s_frd[0], s_nrd[1], s_frd[1]}, 0);
    chk("midrst_depth", s_depth[0], 0);
    @(posedge clk) #1;
    reset = 0;
    @(posedge clk) #1;
    run(60, 12, 8'h66, 8'h66, 3, 4'b0101, 4'b0101, 0);
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/tree_traversal_unit.md
Name: tree_traversal_unit

Overview:
- Sequential successor to the single-comparison decision control unit in the SADDC tree datapath.
- Walks one complete decision tree for one feature vector: fetches node records and features from external synchronous memories, compares feature against threshold each level, follows left/right child until a leaf, and returns class, depth and per-level decision trace.
- Sits between the tree/feature RAMs and the ensemble vote/accumulate stage; one traversal in flight at a time.

Parameters:
- DATA_W, 32, feature and threshold width
- NODE_AW, 8, node memory address width (tree up to 2^NODE_AW nodes)
- FEAT_AW, 5, feature index width (feature vector up to 2^FEAT_AW entries)
- CLASS_W, 8, leaf class label width
- MAX_DEPTH, 16, maximum internal nodes visited before abort; >=1
- CMP_SIGNED, 0, 1 = two's-complement compare, 0 = unsigned

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- io_start_valid  in  1  traversal request
- io_start_ready  out  1  unit idle, can accept request
- io_root_addr  in  NODE_AW  root node address, sampled on start handshake
- io_node_rd_en  out  1  node memory read strobe
- io_node_addr  out  NODE_AW  node memory address
- io_node_is_leaf  in  1  node record: leaf flag (valid 1 cycle after rd_en)
- io_node_feat  in  FEAT_AW  node record: feature index
- io_node_thresh  in  DATA_W  node record: threshold
- io_node_left  in  NODE_AW  node record: left child
- io_node_right  in  NODE_AW  node record: right child
- io_node_class  in  CLASS_W  node record: class label (leaf only)
- io_feat_rd_en  out  1  feature memory read strobe
- io_feat_addr  out  FEAT_AW  feature memory address
- io_feat_rdata  in  DATA_W  feature value (valid 1 cycle after rd_en)
- io_res_valid  out  1  result available
- io_res_ready  in  1  downstream accepts result
- io_res_class  out  CLASS_W  leaf class
- io_res_depth  out  clog2(MAX_DEPTH+1)  internal nodes visited
- io_res_path  out  MAX_DEPTH  decision trace, bit i = decision at level i (1 = right)
- io_res_err  out  1  depth limit exceeded, class invalid

Behaviour:
- Reset (async assert, sync deassert at clk): state IDLE, io_start_ready=1, io_res_valid=0, io_res_class=0, io_res_depth=0, io_res_path=0, io_res_err=0, both rd_en=0, addresses 0.
- States: IDLE, NODE, NLAT, FLAT, DONE.
- IDLE: start_ready=1; on start_valid&start_ready latch cur=root_addr, clear depth/path/err -> NODE.
- NODE: node_rd_en=1, node_addr=cur -> NLAT.
- NLAT: node record valid, latched. is_leaf=1 -> res_class=node_class -> DONE. Else feat_rd_en=1, feat_addr=node_feat, latch thresh/left/right -> FLAT.
- FLAT: decision = feat_rdata > thresh (signed per CMP_SIGNED); path[depth]=decision; cur = decision ? right : left; depth+=1. If new depth == MAX_DEPTH: err=1, class=0 -> DONE; else -> NODE.
- Equality (feature == threshold) goes left.
- DONE: res_valid=1, outputs stable until res_valid&res_ready -> IDLE. start_ready=0 in every non-IDLE state; start_valid ignored.
- Latency: accept cycle = 0; res_valid asserts at cycle 3k+3 for k internal nodes; error case asserts at 3*MAX_DEPTH+1.
- rd_en strobes are single-cycle, never both high in the same cycle; addresses are don't-care when strobe low but held at last value.
- Path bits >= depth read 0.
- Reset mid-traversal: immediately returns to reset values; no result produced; in-flight memory returns ignored.
- No cycle detection beyond MAX_DEPTH; a self-looping tree terminates via err.

Test Plan:
- Root is leaf, class=0x2A -> res_valid at cycle 3, class=0x2A, depth=0, path=0, err=0; single node read, zero feature reads.
- Depth-2 tree, root thresh=100 feat[3]=150 (right), child thresh=50 feat[1]=50 (equal -> left), leaf class=7 -> res_valid at cycle 9, class=7, depth=2, path=0b01.
- CMP_SIGNED=1, thresh=0x00000005, feature=0xFFFFFFFF -> left; same stimulus with CMP_SIGNED=0 -> right.
- Node self-loop with MAX_DEPTH=4 -> res_valid at cycle 13, err=1, depth=4, class=0.
- Hold res_ready=0 for 5 cycles with start_valid=1 -> outputs stable, start_ready=0, no new accept; release -> IDLE, next start accepted the cycle after the result handshake.
- Assert reset during FLAT of a 3-level walk -> outputs return to reset values that cycle; fresh start after deassert completes with correct result.
